// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if -- exception controller <-> cp0 bus.
//
// Carries the cp0-side traffic of the exception controller:
//   master (exc_ctrl): drives cause_ip, exc_code, exc_epc, exc_badvaddr;
//                      receives exc_jmp_flag, int_timer_req, status.
//   slave  (cp0)     : the mirror image.
// The cp0 definitions (EXC_CODE_WIDTH, INT_MASK_WIDTH, EC_* codes) are
// provided here behind an include guard so every file of the bundle sees
// one consistent set.

`ifndef CP0_DEF_VH
`define CP0_DEF_VH
`define EXC_CODE_WIDTH 5
`define INT_MASK_WIDTH 8
`define EC_INT  5'h00
`define EC_TLBL 5'h02
`define EC_TLBS 5'h03
`define EC_ADEL 5'h04
`define EC_ADES 5'h05
`define EC_SYS  5'h08
`define EC_BP   5'h09
`define EC_RI   5'h0a
`define EC_OV   5'h0c
`define EC_ERET 5'h1e
`define EC_NONE 5'h1f
`endif

interface exc_ctrl_if;
  logic [`INT_MASK_WIDTH-1:0] cause_ip;
  logic [`EXC_CODE_WIDTH-1:0] exc_code;
  logic [31:0]                exc_epc;
  logic [31:0]                exc_badvaddr;
  logic                       exc_jmp_flag;
  logic                       int_timer_req;
  logic [31:0]                status;

  modport master (
    output cause_ip, exc_code, exc_epc, exc_badvaddr,
    input  exc_jmp_flag, int_timer_req, status
  );

  modport slave (
    input  cause_ip, exc_code, exc_epc, exc_badvaddr,
    output exc_jmp_flag, int_timer_req, status
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl -- exception/interrupt controller in front of cp0.
//
// Collects the MEM-stage exception/ERET request plus the interrupt lines,
// masks interrupts against Status, picks at most one event, hands it to cp0
// for exactly one cycle and keeps the pipeline flushed until cp0 redirects
// (exc_jmp_flag) or three WAIT cycles elapse (sticky exc_timeout).
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   hw_int[4:0]         raw asynchronous external interrupt levels
//   mem_valid           MEM stage holds a real instruction
//   mem_exc_code        MEM exception code (EC_NONE / EC_ERET / fault)
//   mem_pc              PC of the MEM instruction
//   mem_in_delay_slot   MEM instruction sits in a delay slot
//   mem_badvaddr        faulting address for address/TLB faults
//   cp0                 exc_ctrl_if.master (cause_ip, exc_code, exc_epc,
//                       exc_badvaddr out; exc_jmp_flag, int_timer_req,
//                       status in)
//   flush               kill IF..MEM and block writeback
//   exc_timeout         sticky: cp0 never acknowledged an event
//
// Build option: define EXC_CTRL_HWINT_SYNC_EN to pass each hw_int bit
// through a 2-flop synchronizer; otherwise a single register stage is used.

module exc_ctrl (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 hw_int,
  input  logic                       mem_valid,
  input  logic [`EXC_CODE_WIDTH-1:0] mem_exc_code,
  input  logic [31:0]                mem_pc,
  input  logic                       mem_in_delay_slot,
  input  logic [31:0]                mem_badvaddr,
  exc_ctrl_if.master                 cp0,
  output logic                       flush,
  output logic                       exc_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 wait_cnt_q, wait_cnt_d;
  logic                       timeout_q, timeout_d;
  logic [`EXC_CODE_WIDTH-1:0] exc_code_q;
  logic [31:0]                exc_epc_q, exc_badvaddr_q;

  logic [4:0] hw_int_p0;
  logic [4:0] hw_sync;
  logic       timer_p0;

  // Interrupt input stage(s)
`ifdef EXC_CTRL_HWINT_SYNC_EN
  logic [4:0] hw_int_p1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hw_int_p0 <= '0;
      hw_int_p1 <= '0;
    end else begin
      hw_int_p0 <= hw_int;
      hw_int_p1 <= hw_int_p0;
    end
  end
  assign hw_sync = hw_int_p1;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hw_int_p0 <= '0;
    else      hw_int_p0 <= hw_int;
  end
  assign hw_sync = hw_int_p0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timer_p0 <= 1'b0;
    else      timer_p0 <= cp0.int_timer_req;
  end

  assign cp0.cause_ip = {timer_p0, hw_sync, 2'b00};

  // Event selection (IDLE only)
  logic                       int_pend, sync_exc, is_eret, capture;
  logic [`EXC_CODE_WIDTH-1:0] sel_code;
  logic [31:0]                sel_epc, sel_badvaddr, pc_epc;

  assign int_pend = cp0.status[0] & ~cp0.status[1] &
                    (|(cp0.cause_ip[7:2] & cp0.status[15:10]));
  assign sync_exc = (mem_exc_code != `EC_NONE) && (mem_exc_code != `EC_ERET);
  assign is_eret  = (mem_exc_code == `EC_ERET);
  assign capture  = (state_q == S_IDLE) && mem_valid && (int_pend || sync_exc || is_eret);
  assign pc_epc   = mem_in_delay_slot ? (mem_pc - 32'd4) : mem_pc;

  always_comb begin
    sel_code     = `EC_ERET;
    sel_epc      = 32'd0;
    sel_badvaddr = 32'd0;
    if (int_pend) begin
      sel_code = `EC_INT;
      sel_epc  = pc_epc;
    end else if (sync_exc) begin
      sel_code     = mem_exc_code;
      sel_epc      = pc_epc;
      sel_badvaddr = mem_badvaddr;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (capture) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = 2'd0;
      end
      S_WAIT: begin
        if (cp0.exc_jmp_flag) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == 2'd2) begin
          // third unanswered WAIT cycle: give up and flag it
          state_d    = S_IDLE;
          wait_cnt_d = 2'd3;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and cp0 output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= 2'd0;
      timeout_q      <= 1'b0;
      exc_code_q     <= `EC_NONE;
      exc_epc_q      <= 32'd0;
      exc_badvaddr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      exc_code_q <= capture ? sel_code : `EC_NONE;
      if (capture) begin
        exc_epc_q      <= sel_epc;
        exc_badvaddr_q <= sel_badvaddr;
      end
    end
  end

  assign cp0.exc_code     = exc_code_q;
  assign cp0.exc_epc      = exc_epc_q;
  assign cp0.exc_badvaddr = exc_badvaddr_q;
  assign exc_timeout      = timeout_q;

  // Gated by rst so flush falls the moment reset asserts, even if the MEM
  // inputs would still qualify a capture.
  assign flush = rst & ((state_q != S_IDLE) | capture);

  logic unused_status;
  assign unused_status = ^{cp0.status[31:16], cp0.status[9:2]};

endmodule
